// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl_if
// Description : Data-memory handshake bundle between the MEM stage and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM pipeline stage: memory handshake, stall/timeout control,
//               branch redirect and the MEM/WB register (falling-edge clocked).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [31:0]        result_in,
    input  logic [31:0]        registro_2_in,
    input  logic [10:0]        jump_dest_addr_in,
    input  logic               zero_signal_in,
    input  logic [4:0]         reg_dest_in,
    input  logic               MemToReg_in,
    input  logic               RegWrite_in,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic               Branch_in,
    mem_stage_ctrl_if.master   mem,
    output logic               stall,
    output logic               PCSrc_out,
    output logic [10:0]        branch_target_out,
    output logic [31:0]        read_data_out,
    output logic [31:0]        result_out,
    output logic [4:0]         reg_dest_out,
    output logic               MemToReg_out,
    output logic               RegWrite_out,
    output logic               align_err,
    output logic               bus_err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_ABORT = 2'd2;

    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_next;
    logic [7:0]  w_wait_cnt_inc;

    logic        w_mem_op;
    logic        w_access;
    logic        w_bad_access;
    logic        w_abort;
    logic        w_stall_raw;
    logic        w_bubble;

    logic [31:0] r_read_data;
    logic [31:0] r_result;
    logic [4:0]  r_reg_dest;
    logic        r_mem_to_reg;
    logic        r_reg_write;

    // Upper address bits lie outside the 2K-word data memory window.
    logic        w_unused;
    assign w_unused = &{1'b0, result_in[31:13]};

    // ------------------------------------------------------------------------
    // Access qualification
    // ------------------------------------------------------------------------
    assign w_mem_op     = MemRead_in | MemWrite_in;
    assign w_access     = w_mem_op & (result_in[1:0] == 2'b00) & ~(MemRead_in & MemWrite_in);
    assign w_bad_access = w_mem_op & ~w_access;
    assign w_abort      = (r_state == c_ABORT);
    assign w_stall_raw  = w_access & ~mem.mem_ready & ~w_abort;
    assign w_bubble     = w_stall_raw | w_abort | w_bad_access;

    // Control outputs are forced low while reset is held, independent of inputs.
    assign mem.mem_req   = w_access & ~w_abort & reset_n;
    assign mem.mem_we    = MemWrite_in & w_access & reset_n;
    assign mem.mem_addr  = result_in[12:2];
    assign mem.mem_wdata = registro_2_in;

    assign stall             = w_stall_raw & reset_n;
    assign PCSrc_out         = Branch_in & zero_signal_in & ~w_stall_raw & reset_n;
    assign branch_target_out = jump_dest_addr_in;
    assign align_err         = w_bad_access & reset_n;
    assign bus_err           = w_abort;

    // ------------------------------------------------------------------------
    // Wait / timeout state machine
    // ------------------------------------------------------------------------
    assign w_wait_cnt_inc = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_access && !mem.mem_ready) begin
                    w_state_next    = c_WAIT;
                    w_wait_cnt_next = 8'd0;
                end
            end
            c_WAIT: begin
                if (!w_access || mem.mem_ready) begin
                    w_state_next = c_IDLE;
                end else begin
                    w_wait_cnt_next = w_wait_cnt_inc;
                    if (w_wait_cnt_inc >= c_WAIT_LAST) begin
                        w_state_next = c_ABORT;
                    end
                end
            end
            c_ABORT: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // MEM/WB register: stalls, aborts and rejected accesses retire as bubbles
    // ------------------------------------------------------------------------
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_read_data  <= 32'd0;
            r_result     <= 32'd0;
            r_reg_dest   <= 5'd0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
        end else if (w_bubble) begin
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
        end else begin
            r_read_data  <= (MemRead_in && w_access) ? mem.mem_rdata : 32'd0;
            r_result     <= result_in;
            r_reg_dest   <= reg_dest_in;
            r_mem_to_reg <= MemToReg_in;
            r_reg_write  <= RegWrite_in;
        end
    end

    assign read_data_out = r_read_data;
    assign result_out    = r_result;
    assign reg_dest_out  = r_reg_dest;
    assign MemToReg_out  = r_mem_to_reg;
    assign RegWrite_out  = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Directed scenarios plus randomized traffic for mem_stage_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;
    localparam int unsigned TO = 15;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] result_in;
    logic [31:0] registro_2_in;
    logic [10:0] jump_dest_addr_in;
    logic        zero_signal_in;
    logic [4:0]  reg_dest_in;
    logic        MemToReg_in;
    logic        RegWrite_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic        Branch_in;
    logic        stall;
    logic        PCSrc_out;
    logic [10:0] branch_target_out;
    logic [31:0] read_data_out;
    logic [31:0] result_out;
    logic [4:0]  reg_dest_out;
    logic        MemToReg_out;
    logic        RegWrite_out;
    logic        align_err;
    logic        bus_err;

    mem_stage_ctrl_if mem_if ();

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .result_in         (result_in),
        .registro_2_in     (registro_2_in),
        .jump_dest_addr_in (jump_dest_addr_in),
        .zero_signal_in    (zero_signal_in),
        .reg_dest_in       (reg_dest_in),
        .MemToReg_in       (MemToReg_in),
        .RegWrite_in       (RegWrite_in),
        .MemRead_in        (MemRead_in),
        .MemWrite_in       (MemWrite_in),
        .Branch_in         (Branch_in),
        .mem               (mem_if),
        .stall             (stall),
        .PCSrc_out         (PCSrc_out),
        .branch_target_out (branch_target_out),
        .read_data_out     (read_data_out),
        .result_out        (result_out),
        .reg_dest_out      (reg_dest_out),
        .MemToReg_out      (MemToReg_out),
        .RegWrite_out      (RegWrite_out),
        .align_err         (align_err),
        .bus_err           (bus_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: stalled-cycle count of the current instruction,
    // pending timeout retirement, and the expected MEM/WB contents.
    int          m_stalls;
    bit          m_abort;
    bit          last_stall;
    logic [31:0] e_rd;
    logic [31:0] e_res;
    logic [4:0]  e_dst;
    logic        e_mtr;
    logic        e_rw;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stalls   = 0;
        m_abort    = 1'b0;
        last_stall = 1'b0;
        e_rd       = 32'd0;
        e_res      = 32'd0;
        e_dst      = 5'd0;
        e_mtr      = 1'b0;
        e_rw       = 1'b0;
    endtask

    task automatic set_idle();
        result_in         = 32'd0;
        registro_2_in     = 32'd0;
        jump_dest_addr_in = 11'd0;
        zero_signal_in    = 1'b0;
        reg_dest_in       = 5'd0;
        MemToReg_in       = 1'b0;
        RegWrite_in       = 1'b0;
        MemRead_in        = 1'b0;
        MemWrite_in       = 1'b0;
        Branch_in         = 1'b0;
        mem_if.mem_ready  = 1'b0;
        mem_if.mem_rdata  = 32'd0;
    endtask

    // One clock cycle: inputs are already applied; check combinational
    // outputs mid-cycle, advance the model, check MEM/WB after the falling edge.
    task automatic step();
        bit acc;
        bit bad;
        bit xs;
        @(posedge clock);
        #1;
        acc = (MemRead_in || MemWrite_in) && (result_in[1:0] == 2'b00) && !(MemRead_in && MemWrite_in);
        bad = (MemRead_in || MemWrite_in) && !acc;
        xs  = acc && !mem_if.mem_ready && !m_abort;
        check("mem_req",   32'(mem_if.mem_req),     32'(acc && !m_abort));
        check("mem_we",    32'(mem_if.mem_we),      32'(MemWrite_in && acc));
        check("mem_addr",  32'(mem_if.mem_addr),    32'(result_in[12:2]));
        check("mem_wdata", mem_if.mem_wdata,        registro_2_in);
        check("stall",     32'(stall),              32'(xs));
        check("pcsrc",     32'(PCSrc_out),          32'(Branch_in && zero_signal_in && !xs));
        check("br_target", 32'(branch_target_out),  32'(jump_dest_addr_in));
        check("align_err", 32'(align_err),          32'(bad));
        check("bus_err",   32'(bus_err),            32'(m_abort));
        if (xs || m_abort || bad) begin
            e_rw  = 1'b0;
            e_mtr = 1'b0;
        end else begin
            e_res = result_in;
            e_dst = reg_dest_in;
            e_mtr = MemToReg_in;
            e_rw  = RegWrite_in;
            e_rd  = (MemRead_in && acc) ? mem_if.mem_rdata : 32'd0;
        end
        if (m_abort) begin
            m_abort  = 1'b0;
            m_stalls = 0;
        end else if (xs) begin
            m_stalls++;
            if (m_stalls >= int'(TO)) m_abort = 1'b1;
        end else begin
            m_stalls = 0;
        end
        last_stall = xs;
        @(negedge clock);
        #1;
        check("wb_rdata",  read_data_out,        e_rd);
        check("wb_result", result_out,           e_res);
        check("wb_dest",   32'(reg_dest_out),    32'(e_dst));
        check("wb_mtr",    32'(MemToReg_out),    32'(e_mtr));
        check("wb_rw",     32'(RegWrite_out),    32'(e_rw));
    endtask

    initial begin
        int n_st;
        int lat;
        int cyc;
        int op;

        set_idle();
        reset_n = 1'b0;
        model_reset();
        #2;
        check("rst_rw",    32'(RegWrite_out), 32'd0);
        check("rst_rdata", read_data_out,     32'd0);
        check("rst_res",   result_out,        32'd0);
        check("rst_buserr", 32'(bus_err),     32'd0);
        @(negedge clock);
        @(negedge clock);
        #1;
        reset_n = 1'b1;

        // Zero-wait load
        result_in = 32'h40; MemRead_in = 1'b1; RegWrite_in = 1'b1; reg_dest_in = 5'd5;
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF;
        #1;
        check("t027_addr",  32'(mem_if.mem_addr), 32'h010);
        check("t027_stall", 32'(stall),           32'd0);
        step();
        check("t027_rdata", read_data_out,        32'hDEADBEEF);
        check("t027_rw",    32'(RegWrite_out),    32'd1);

        // Store with three wait cycles
        set_idle();
        result_in = 32'h8; registro_2_in = 32'h12345678; MemWrite_in = 1'b1; reg_dest_in = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t028_stall", 32'(stall),         32'd1);
            check("t028_we",    32'(mem_if.mem_we), 32'd1);
            check("t028_wdata", mem_if.mem_wdata,   32'h12345678);
            step();
            check("t028_bubble", 32'(RegWrite_out), 32'd0);
        end
        mem_if.mem_ready = 1'b1;
        step();
        check("t028_done_dest", 32'(reg_dest_out), 32'd9);

        // Load that times out
        set_idle();
        result_in = 32'h100; MemRead_in = 1'b1; RegWrite_in = 1'b1; reg_dest_in = 5'd3;
        n_st = 0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!stall) break;
            n_st++;
            step();
        end
        check("t029_stalls",  32'(n_st),           32'(TO));
        check("t029_buserr",  32'(bus_err),        32'd1);
        check("t029_req",     32'(mem_if.mem_req), 32'd0);
        step();
        check("t029_rw",      32'(RegWrite_out),   32'd0);
        set_idle();
        #1;
        check("t029_idle",    32'(bus_err),        32'd0);
        step();

        // Misaligned store
        result_in = 32'h6; MemWrite_in = 1'b1; RegWrite_in = 1'b1;
        #1;
        check("t030_req",   32'(mem_if.mem_req), 32'd0);
        check("t030_align", 32'(align_err),      32'd1);
        check("t030_stall", 32'(stall),          32'd0);
        step();
        set_idle();
        #1;
        check("t030_clear", 32'(align_err),      32'd0);

        // Branch redirect, then branch behind a pending stall
        Branch_in = 1'b1; zero_signal_in = 1'b1; jump_dest_addr_in = 11'h123;
        #1;
        check("t031_pcsrc",  32'(PCSrc_out),         32'd1);
        check("t031_target", 32'(branch_target_out), 32'h123);
        step();
        result_in = 32'h20; MemRead_in = 1'b1;
        #1;
        check("t031_pcsrc_stall", 32'(PCSrc_out), 32'd0);
        step();
        mem_if.mem_ready = 1'b1;
        step();

        // Reset during WAIT
        set_idle();
        result_in = 32'h200; MemRead_in = 1'b1; RegWrite_in = 1'b1; reg_dest_in = 5'd7;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("t032_req",    32'(mem_if.mem_req), 32'd0);
        check("t032_stall",  32'(stall),          32'd0);
        check("t032_res",    result_out,          32'd0);
        check("t032_rdata",  read_data_out,       32'd0);
        check("t032_rw",     32'(RegWrite_out),   32'd0);
        check("t032_buserr", 32'(bus_err),        32'd0);
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hCAFEF00D;
        @(negedge clock);
        #1;
        check("t032_hold_rdata", read_data_out,   32'd0);
        check("t032_hold_dest",  32'(reg_dest_out), 32'd0);
        mem_if.mem_ready = 1'b0;
        reset_n = 1'b1;
        model_reset();
        #1;
        check("t032_req_after", 32'(mem_if.mem_req), 32'd1);
        step();
        mem_if.mem_ready = 1'b1;
        step();

        // Randomized traffic; EX/MEM inputs hold while the stage stalls
        for (int k = 0; k < 300; k++) begin
            set_idle();
            op                = int'($urandom_range(0, 7));
            result_in         = $urandom;
            result_in[1:0]    = (op == 6) ? 2'($urandom_range(1, 3)) : 2'b00;
            MemRead_in        = (op == 1 || op == 2 || op == 7 || (op == 6 && $urandom_range(0, 1) == 0));
            MemWrite_in       = (op == 3 || op == 7 || (op == 6 && !MemRead_in));
            registro_2_in     = $urandom;
            jump_dest_addr_in = 11'($urandom);
            zero_signal_in    = 1'($urandom);
            reg_dest_in       = 5'($urandom);
            MemToReg_in       = 1'($urandom);
            RegWrite_in       = 1'($urandom);
            Branch_in         = 1'($urandom);
            lat = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 3));
            cyc = 0;
            do begin
                mem_if.mem_ready = (cyc >= lat);
                mem_if.mem_rdata = $urandom;
                step();
                cyc++;
            end while (last_stall && cyc < 64);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max falling edges WAIT holds before abort (range 1..255).
REQ-002 SHALL have port clock, input, 1, single clock; all state updates on its falling edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports result_in [31:0], registro_2_in [31:0], jump_dest_addr_in [10:0], zero_signal_in, reg_dest_in [4:0], inputs: EX/MEM datapath (address/ALU result, store data, branch target, zero flag, dest reg).
REQ-005 SHALL have ports MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in, inputs, 1 each: EX/MEM control.
REQ-006 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 11, word address), mem_wdata (out, 32), mem_rdata (in, 32), mem_ready (in, 1): data-memory handshake.
REQ-007 SHALL have port stall, output, 1: freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-008 SHALL have ports PCSrc_out (out, 1) and branch_target_out (out, 11): branch redirect to IF.
REQ-009 SHALL have ports read_data_out [31:0], result_out [31:0], reg_dest_out [4:0], MemToReg_out, RegWrite_out, outputs: registered MEM/WB stage.
REQ-010 SHALL have ports align_err and bus_err, outputs, 1 each: one-cycle error pulses.

Function
REQ-011 SHALL define access = (MemRead_in | MemWrite_in) & result_in[1:0]==0 & !(MemRead_in & MemWrite_in).
REQ-012 SHALL drive mem_addr = result_in[12:2], mem_wdata = registro_2_in, mem_we = MemWrite_in & access, mem_req = access & state!=ABORT, combinationally.
REQ-013 SHALL implement FSM {IDLE, WAIT, ABORT}; reset state IDLE.
REQ-014 IDLE: access & !mem_ready -> WAIT, wait counter cleared to 0; access & mem_ready -> stay IDLE (zero-wait completion); else stay IDLE.
REQ-015 WAIT: mem_ready -> IDLE (completion); else counter+1; counter reaching TIMEOUT-1 without mem_ready -> ABORT.
REQ-016 ABORT: lasts exactly one cycle; mem_req low; bus_err=1; -> IDLE, current instruction retired as bubble.
REQ-017 SHALL assert stall = access & !mem_ready & state!=ABORT.
REQ-018 On a falling edge with stall=1, MEM/WB SHALL load a bubble: RegWrite_out=0, MemToReg_out=0; other MEM/WB outputs hold.
REQ-019 On a falling edge with stall=0, MEM/WB SHALL load result_in, reg_dest_in, MemToReg_in, RegWrite_in, and read_data_out = mem_rdata if MemRead_in & access completed this cycle, else 0.
REQ-020 Misaligned access (result_in[1:0]!=0) or MemRead_in&MemWrite_in both 1: no mem_req, no stall, align_err=1 for that cycle, MEM/WB loads bubble.
REQ-021 ABORT cycle SHALL load bubble into MEM/WB and de-assert stall so the pipeline advances.
REQ-022 PCSrc_out = Branch_in & zero_signal_in & !stall; branch_target_out = jump_dest_addr_in; both combinational.
REQ-023 Store SHALL hold mem_we, mem_addr, mem_wdata stable for every cycle mem_req is high until mem_ready.
REQ-024 Wait counter SHALL be 8 bits, saturating, cleared on every entry to WAIT.

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE, counter 0, read_data_out=0, result_out=0, reg_dest_out=0, MemToReg_out=0, RegWrite_out=0, align_err=0, bus_err=0.
REQ-026 Reset asserted mid-WAIT SHALL abandon the access with no MEM/WB write; mem_req follows combinational rule once reset_n=1.

Verification
REQ-027 Load result_in=0x40, MemRead_in=1, RegWrite_in=1, mem_ready=1 same cycle, mem_rdata=0xDEADBEEF -> stall=0, mem_addr=0x010, next edge read_data_out=0xDEADBEEF, RegWrite_out=1.
REQ-028 Store result_in=0x8, registro_2_in=0x12345678, mem_ready low 3 cycles -> stall=1 3 cycles, mem_we=1, mem_wdata stable, 3 bubbles in MEM/WB, then completion.
REQ-029 Load with mem_ready never asserted, TIMEOUT=15 -> stall 15 cycles, ABORT cycle bus_err=1, RegWrite_out=0, return IDLE.
REQ-030 result_in=0x6, MemWrite_in=1 -> mem_req=0, align_err=1 one cycle, stall=0, bubble.
REQ-031 Branch_in=1, zero_signal_in=1, jump_dest_addr_in=0x123, no access -> PCSrc_out=1, branch_target_out=0x123; same with pending stall -> PCSrc_out=0.
REQ-032 reset_n pulsed low during WAIT -> all outputs 0 immediately, state IDLE, no MEM/WB write of pending load.
